mux4_reg: RTL and testbench

- Registered 4-to-1 multiplexer with a parameterised data width.
- Selects one of four operand buses (a, b, c, d) using a 2-bit select and presents the result one clock later with a valid flag.
- Used as a generic datapath steering element, e.g. choosing one of several constant or operand sources feeding downstream logic.

---
 rtl/mux4_pkg.sv | 11 +
 rtl/mux4_comb.sv | 27 ++
 rtl/mux4_reg.sv | 55 +++++
 tb/tb_mux4_reg.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mux4_pkg.sv
// rtl/mux4_pkg.sv - select encodings shared by the mux4 datapath
package mux4_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'd0;
  localparam sel_t SEL_B = 2'd1;
  localparam sel_t SEL_C = 2'd2;
  localparam sel_t SEL_D = 2'd3;

endpackage

// File: rtl/mux4_comb.sv
// rtl/mux4_comb.sv - combinational WIDTH-bit 4:1 select
module mux4_comb
  import mux4_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0] d_i,
  input  sel_t             sel_i,
  output logic [WIDTH-1:0] y_o
);

  // Unknown select codes fall back to a so nothing is held in a latch.
  always_comb begin
    y_o = a_i;
    case (sel_i)
      SEL_A:   y_o = a_i;
      SEL_B:   y_o = b_i;
      SEL_C:   y_o = c_i;
      SEL_D:   y_o = d_i;
      default: y_o = a_i;
    endcase
  end

endmodule

// File: rtl/mux4_reg.sv
// rtl/mux4_reg.sv - registered 4:1 mux with a one-cycle valid flag
module mux4_reg
  import mux4_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;

  mux4_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i   (a),
    .b_i   (b),
    .c_i   (c),
    .d_i   (d),
    .sel_i (sel_t'(sel)),
    .y_o   (sel_data)
  );

  // Data holds when idle; the valid flag only marks the edge that loaded it.
  always_comb begin
    out_d   = out_q;
    valid_d = 1'b0;
    if (in_valid) begin
      out_d   = sel_data;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux4_reg.sv
// tb/tb_mux4_reg.sv - directed and random checks of mux4_reg at WIDTH 4 and 8
module tb_mux4_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel;
  logic       in_valid;
  logic [3:0] ins4 [4];
  logic [7:0] ins8 [4];
  logic [3:0] out4;
  logic [7:0] out8;
  logic       vld4, vld8;

  logic [3:0] exp4;
  logic [7:0] exp8;
  logic       expv;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux4_reg #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .a(ins4[0]), .b(ins4[1]), .c(ins4[2]), .d(ins4[3]),
    .sel(sel), .in_valid(in_valid),
    .out(out4), .out_valid(vld4)
  );

  mux4_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .a(ins8[0]), .b(ins8[1]), .c(ins8[2]), .d(ins8[3]),
    .sel(sel), .in_valid(in_valid),
    .out(out8), .out_valid(vld8)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv_i);
    tests++;
    assert (obs === expv_i)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv_i);
    end
  endtask

  // One clock edge: the reference register picks the indexed operand when
  // valid, clears on reset, otherwise keeps its value with valid dropped.
  task automatic step(input string tag);
    @(posedge clk);
    if (rst) begin
      exp4 = '0; exp8 = '0; expv = 1'b0;
    end else if (in_valid) begin
      exp4 = ins4[sel]; exp8 = ins8[sel]; expv = 1'b1;
    end else begin
      expv = 1'b0;
    end
    #1;
    check({tag, ".out4"}, {4'h0, out4}, {4'h0, exp4});
    check({tag, ".vld4"}, {7'h0, vld4}, {7'h0, expv});
    check({tag, ".out8"}, out8, exp8);
    check({tag, ".vld8"}, {7'h0, vld8}, {7'h0, expv});
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 4; i++) begin
      ins4[i] = 4'($urandom);
      ins8[i] = 8'($urandom);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; sel = 2'($urandom);
    exp4 = '0; exp8 = '0; expv = 1'b0;
    randomize_inputs();

    // Reset held for two edges with valid input present
    step("reset0");
    randomize_inputs(); sel = 2'($urandom);
    step("reset1");
    rst = 1'b0;
    step("first_capture");

    // Select sweep at both widths
    ins4[0] = 4'h4; ins4[1] = 4'h8; ins4[2] = 4'hC; ins4[3] = 4'hF;
    ins8[0] = 8'hA5; ins8[1] = 8'h5A; ins8[2] = 8'hFF; ins8[3] = 8'h00;
    in_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      step("sweep");
    end

    // Hold after capturing sel=3
    sel = 2'd3;
    step("hold_capture");
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      randomize_inputs(); sel = 2'($urandom);
      step("hold");
    end

    // Input change without valid, then a single capture
    sel = 2'd0; ins4[0] = 4'h4;
    step("noval_a4");
    ins4[0] = 4'h9;
    step("noval_a9");
    in_valid = 1'b1;
    step("capture_a9");

    // Reset on the same edge as a valid capture
    ins4[2] = 4'hC; ins8[2] = 8'hFF; sel = 2'd2; rst = 1'b1;
    step("mid_reset");
    rst = 1'b0;
    step("after_reset");

    // Random traffic with occasional reset
    for (int n = 0; n < 300; n++) begin
      randomize_inputs();
      sel      = 2'($urandom);
      in_valid = 1'($urandom);
      rst      = ($urandom_range(0, 15) == 0);
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
